// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// Receive-side serial front end. Oversamples the RX line, tracks each frame
// through start/data/parity/stop, and hands good bytes to the receive FIFO
// with a one-clock write strobe. Framing, parity and overrun conditions are
// reported as one-clock pulses in the same slot as the write strobe.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rx_i,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       fifofull,
    output logic [7:0] rx_data,
    output logic       fifowr,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    // Tick index of the middle of the start bit, and of the next bit centre
    // once the counter has been re-aligned to mid-bit.
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 mismatch;
    logic                 sample;

    // Expected parity bit for the received data: even parity is the XOR of
    // the data bits, odd parity its complement.
    function automatic logic parity_expect(input logic [DATA_BITS-1:0] d,
                                           input logic odd);
        return (^d) ^ odd;
    endfunction

    // Bit-centre sample point while inside a data, parity or stop bit.
    assign sample = baud_tick && (cnt == CNT_LAST);

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Frame sequencing: next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (baud_tick && !rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (baud_tick && (cnt == CNT_MID)) state_nxt = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample && (bit_idx == IDX_LAST)) state_nxt = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (sample) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (sample) state_nxt = rx_s ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (baud_tick && rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, tick counter, bit index, shift register and per-frame settings.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (baud_tick && !rx_s) begin
                        cnt       <= '0;
                        par_en_q  <= parity_en;
                        par_odd_q <= parity_odd;
                        mismatch  <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        if (cnt == CNT_MID) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DATA, S_PARITY, S_STOP: begin
                    if (baud_tick) cnt <= sample ? '0 : cnt + 1'b1;
                    if (sample && (state == S_DATA)) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                    if (sample && (state == S_PARITY)) begin
                        mismatch <= (rx_s != parity_expect(shreg, par_odd_q));
                    end
                end
                default: ;
            endcase
        end
    end

    // Stop-bit verdict: registered strobe, error pulses and accepted byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data     <= '0;
            fifowr      <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            fifowr      <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            if ((state == S_STOP) && sample) begin
                if (rx_s) begin
                    if (!fifofull) begin
                        rx_data    <= 8'(shreg);
                        fifowr     <= 1'b1;
                        parity_err <= mismatch;
                    end else begin
                        overrun_err <= 1'b1;
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives whole frames on rx_i with
// baud_tick every 4 clk and checks strobes, error pulses and rx_data.
module tb_uart_rx_deserializer;

    localparam int OS      = 16;
    localparam int DB      = 8;
    localparam int BIT_CLK = 4 * OS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_i = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       fifofull = 1'b0;
    logic [7:0] rx_data;
    logic       fifowr;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       busy;

    uart_rx_deserializer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .rx_i       (rx_i),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .fifofull   (fifofull),
        .rx_data    (rx_data),
        .fifowr     (fifowr),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk high out of every four.
    logic [1:0] tdiv = 2'd0;
    always @(posedge clk) begin
        tdiv      <= tdiv + 2'd1;
        baud_tick <= (tdiv == 2'd3);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor, sampled on the falling edge.
    int         fw_n = 0, fe_n = 0, pe_n = 0, ov_n = 0, pe_fw_n = 0, excl_n = 0, tick_n = 0;
    logic [7:0] fw_data[$];
    int         fw_tick[$];
    always @(negedge clk) begin
        if (baud_tick) tick_n++;
        if (fifowr) begin
            fw_n++;
            fw_data.push_back(rx_data);
            fw_tick.push_back(tick_n);
        end
        if (frame_err) fe_n++;
        if (parity_err) pe_n++;
        if (overrun_err) ov_n++;
        if (parity_err && fifowr) pe_fw_n++;
        if (frame_err && (fifowr || parity_err || overrun_err)) excl_n++;
        if (fifowr && overrun_err) excl_n++;
        if (parity_err && !fifowr) excl_n++;
    end

    int b_fw, b_fe, b_pe, b_ov, b_pefw;
    task automatic mark();
        b_fw = fw_n; b_fe = fe_n; b_pe = pe_n; b_ov = ov_n; b_pefw = pe_fw_n;
    endtask

    task automatic expect_pulses(input string tag, input int fw, input int fe,
                                 input int pe, input int ov);
        chk({tag, ".fifowr"},      fw_n - b_fw, fw);
        chk({tag, ".frame_err"},   fe_n - b_fe, fe);
        chk({tag, ".parity_err"},  pe_n - b_pe, pe);
        chk({tag, ".overrun_err"}, ov_n - b_ov, ov);
    endtask

    task automatic bit_time(input logic v);
        rx_i = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) bit_time(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par,
                              input logic pbit, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < DB; i++) bit_time(d[i]);
        if (has_par) bit_time(pbit);
        bit_time(stop);
        rx_i = 1'b1;
    endtask

    int k;

    initial begin
        // Reset
        repeat (4) @(negedge clk);
        chk("rst.rx_data", int'(rx_data), 0);
        chk("rst.fifowr", int'(fifowr), 0);
        chk("rst.errs", int'({frame_err, parity_err, overrun_err}), 0);
        chk("rst.busy", int'(busy), 0);
        rst_n = 1'b1;
        idle_bits(1);

        // Good frame, no parity
        mark();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        expect_pulses("good", 1, 0, 0, 0);
        chk("good.rx_data", int'(rx_data), 'hA5);
        chk("good.busy", int'(busy), 0);

        // Glitch rejection: 3 ticks low
        mark();
        rx_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch.busy_hi", int'(busy), 1);
        rx_i = 1'b1;
        repeat (32) @(negedge clk);
        chk("glitch.busy_lo", int'(busy), 0);
        idle_bits(1);
        expect_pulses("glitch", 0, 0, 0, 0);

        // Framing error, line held low 40 ticks from the stop bit
        mark();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (40 * 4 - BIT_CLK) @(negedge clk);
        chk("frame.wait_busy", int'(busy), 1);
        rx_i = 1'b1;
        idle_bits(12);
        expect_pulses("frame", 0, 1, 0, 0);
        chk("frame.busy", int'(busy), 0);
        mark();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        expect_pulses("after_frame", 1, 0, 0, 0);
        chk("after_frame.rx_data", int'(rx_data), 'h11);

        // Parity error (odd parity, 8'h07 needs parity bit 0)
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        mark();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        expect_pulses("par_bad", 1, 0, 1, 0);
        chk("par_bad.coincide", pe_fw_n - b_pefw, 1);
        chk("par_bad.rx_data", int'(rx_data), 'h07);
        mark();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        expect_pulses("par_good", 1, 0, 0, 0);
        chk("par_good.rx_data", int'(rx_data), 'h07);
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Overrun
        mark();
        fifofull = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        fifofull = 1'b0;
        idle_bits(1);
        expect_pulses("overrun", 0, 0, 0, 1);
        chk("overrun.rx_data", int'(rx_data), 'h07);

        // Back-to-back frames
        mark();
        k = fw_data.size();
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        expect_pulses("b2b", 2, 0, 0, 0);
        if (fw_data.size() >= k + 2) begin
            chk("b2b.first", int'(fw_data[k]), 'h00);
            chk("b2b.second", int'(fw_data[k+1]), 'hFF);
            chk("b2b.spacing", fw_tick[k+1] - fw_tick[k], 10 * OS);
        end

        // Reset in the middle of a data bit
        mark();
        rx_i = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rx_i = 1'b1;
        repeat (BIT_CLK + BIT_CLK / 2) @(negedge clk);
        chk("midrst.busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.rx_data", int'(rx_data), 0);
        chk("midrst.pulses", int'({fifowr, frame_err, parity_err, overrun_err}), 0);
        rst_n = 1'b1;
        idle_bits(12);
        expect_pulses("midrst", 0, 0, 0, 0);
        mark();
        send_frame(8'h96, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        expect_pulses("post_rst", 1, 0, 0, 0);
        chk("post_rst.rx_data", int'(rx_data), 'h96);
        chk("post_rst.busy", int'(busy), 0);

        chk("exclusive_pulses", excl_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

- Serial front end of the UART receive path.
- Oversamples the asynchronous RX line, validates start, data, parity and stop bits, and recovers each byte.
- Issues a single-cycle write strobe to the receive FIFO pointer controller when a good frame completes, gated by that FIFO's full flag.
- Reports framing, parity and overrun errors as single-cycle pulses aligned to the write strobe slot.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..8.
- OVERSAMPLE, 16, baud_tick pulses per bit period, even, ≥4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- baud_tick  in  1  one-clk enable pulse at OVERSAMPLE × baud rate.
- rx_i  in  1  asynchronous serial line; idle high.
- parity_en  in  1  1 = a parity bit follows the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even; ignored when parity_en=0.
- fifofull  in  1  full flag from the receive FIFO.
- rx_data  out  8  last accepted byte, LSB-aligned; unused upper bits are 0.
- fifowr  out  1  one-clk write strobe to the receive FIFO.
- frame_err  out  1  one-clk pulse: stop bit sampled 0.
- parity_err  out  1  one-clk pulse: parity mismatch.
- overrun_err  out  1  one-clk pulse: good byte dropped because the FIFO was full.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- **Synchronizer.** rx_i passes through a 2-flop synchronizer to give rx_s. Both flops reset to 1.
- **Tick counter.** cnt is $clog2(OVERSAMPLE) bits wide and advances only on baud_tick.
- **Bit index.** bit_idx is 3 bits wide.
- **Shift register.** Data bits are shifted in LSB first.
- **IDLE.**
  - On a baud_tick with rx_s=0: cnt←0, go to START.
- **START.**
  - Each tick: cnt++.
  - On the tick where cnt = OVERSAMPLE/2−1 (mid start bit):
    - rx_s=1: false start; return to IDLE with no outputs.
    - rx_s=0: cnt←0, bit_idx←0, go to DATA.
- **Sample event.** In DATA, PARITY and STOP, a sample event is the tick where cnt = OVERSAMPLE−1. At that tick cnt wraps to 0.
- **DATA.**
  - On each sample event: shift rx_s in, bit_idx++.
  - After DATA_BITS samples: go to PARITY if parity_en, else STOP.
- **PARITY.**
  - On the sample event, compare the sampled bit against the XOR of the data bits, with that XOR inverted when parity_odd=1.
  - Latch the mismatch result, then go to STOP.
- **STOP, on its sample event:**
  - Stop=1, fifofull=0: load rx_data, pulse fifowr. Also pulse parity_err if the latched mismatch is set. Go to IDLE.
  - Stop=1, fifofull=1: pulse overrun_err, leave rx_data unchanged, no fifowr. Go to IDLE.
  - Stop=0: pulse frame_err, no fifowr, rx_data unchanged. Go to WAIT_HIGH.
- **Parity error handling.** The byte is still written; parity_err accompanies its fifowr.
- **WAIT_HIGH.**
  - Stay until a baud_tick sees rx_s=1, then go to IDLE.
  - This prevents a held-low line or break from re-triggering frames.
- **parity_en / parity_odd.** Sampled on the IDLE→START transition and held for the rest of the frame.
- **Reset.** Synchronous reset forces IDLE, cnt=0, bit_idx=0, shift register 0, mismatch flag 0, synchronizer flops 1. This applies mid-frame as well; the partial frame is discarded.

## Timing
- Reset values: rx_data=0, fifowr=0, frame_err=0, parity_err=0, overrun_err=0, busy=0.
- All outputs are registered.
- Pulses (fifowr and error flags):
  - They assert in the clk cycle after the edge that processes the stop sample event, for exactly one clk.
  - rx_data becomes valid in the same cycle fifowr asserts and holds until the next accepted frame.
- fifowr and overrun_err are mutually exclusive, and frame_err excludes all other pulses. The only pulse pair that can coincide is fifowr with parity_err.
- fifofull is sampled on the stop sample edge only.
- Input latency: 2 clk synchronizer delay plus up to 1 tick detection delay after the line falls.
- Frame to strobe: fifowr follows the start edge by (OVERSAMPLE/2) + OVERSAMPLE·(DATA_BITS + parity_en + 1) ticks, plus the detection latency.
- Back-to-back frames: the block is in IDLE at mid-stop, so a start bit immediately following the stop bit is caught.
- baud_tick arriving on consecutive clks is legal.
- With no baud_tick, state and cnt are frozen.

## Test plan
- **Good frame, no parity.**
  - Stimulus: baud_tick every 4 clk, parity_en=0; send 8'hA5 with stop=1.
  - Required: exactly one fifowr, rx_data=8'hA5, no error pulses, busy low afterwards.
- **Glitch rejection.**
  - Stimulus: rx_i low for 3 ticks, then high.
  - Required: START aborts to IDLE, no pulses, busy returns to 0 within 8 ticks.
- **Framing error.**
  - Stimulus: send 8'h3C with stop=0, line held low for 40 ticks, then high; then send 8'h11.
  - Required: frame_err pulses once, no fifowr for 8'h3C, no re-trigger while the line is low.
  - Then 8'h11 gives fifowr with rx_data=8'h11.
- **Parity error.**
  - Stimulus: parity_en=1, parity_odd=1; send 8'h07 with parity bit 1 (correct value is 0).
  - Required: fifowr with rx_data=8'h07 and parity_err in the same cycle.
  - Resending with parity bit 0: fifowr, no parity_err.
- **Overrun.**
  - Stimulus: fifofull=1 during the stop bit of 8'h5A.
  - Required: overrun_err pulse, no fifowr, rx_data holds its prior value.
- **Back-to-back frames and reset.**
  - Stimulus: 8'h00 then 8'hFF with no idle gap.
  - Required: two fifowr pulses 10·OVERSAMPLE ticks apart.
  - Then: rst_n=0 for 1 clk mid-data of a third frame.
  - Required: all outputs 0, IDLE, and the next full frame is received correctly.
